// File: rtl/pipeline_wb_stage_if.sv
// Delayed-branch queue handshake between stage 3 / fetch and writeback.
// master drives push and fetch-ready; slave (writeback) returns queue status.
interface pipeline_wb_stage_if #(
  parameter int DATA_W = 16
);
  logic              dbr_push;
  logic [DATA_W-1:0] dbr_target_in;
  logic              fetch_next_in;
  logic              dbr_full;
  logic              dbr_valid_out;
  logic [DATA_W-1:0] dbr_target_out;

  modport master (
    output dbr_push,
    output dbr_target_in,
    output fetch_next_in,
    input  dbr_full,
    input  dbr_valid_out,
    input  dbr_target_out
  );

  modport slave (
    input  dbr_push,
    input  dbr_target_in,
    input  fetch_next_in,
    output dbr_full,
    output dbr_valid_out,
    output dbr_target_out
  );
endinterface

// File: rtl/pipeline_wb_stage.sv
// Writeback stage: stage reg, load/ALU select, delayed-branch queue.
// Define WB_BYPASS_EN to add the one-cycle forwarding register.
module pipeline_wb_stage #(
  parameter int         DATA_W    = 16,
  parameter int         REG_AW    = 3,
  parameter int         CTRL_W    = 22,
  parameter logic [2:0] OPC_LDR   = 3'b011,
  parameter int         DBR_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] rdata_in,
  pipeline_wb_stage_if.slave dbr,
  output logic              wb_en_out,
  output logic [REG_AW-1:0] wb_num_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_num,
  output logic [DATA_W-1:0] byp_data
);

  localparam int CW = $clog2(DBR_DEPTH + 1);
  localparam int PW = (DBR_DEPTH > 1) ? $clog2(DBR_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DBR_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DBR_DEPTH);

  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_result;
  logic              take;

  assign take = in_valid & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid  <= 1'b0;
      s_ctrl   <= '0;
      s_result <= '0;
    end else begin
      s_valid <= take;
      if (take) begin
        s_ctrl   <= control_in;
        s_result <= result_in;
      end
    end
  end

  logic [2:0] opc;
  assign opc = s_ctrl[CTRL_W-1 -: 3];

  assign wb_en_out   = s_valid & s_ctrl[REG_AW];
  assign wb_num_out  = s_ctrl[REG_AW-1:0];
  assign wb_data_out = (opc == OPC_LDR) ? rdata_in : s_result;

  logic [DATA_W-1:0] mem [DBR_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              pop;
  logic              push_ok;

  assign dbr.dbr_full       = (count == FULL);
  assign dbr.dbr_valid_out  = (count != '0);
  assign dbr.dbr_target_out = mem[rd_ptr];

  assign pop     = dbr.fetch_next_in & dbr.dbr_valid_out;
  // a pop frees a slot in the same edge, so a full queue can still accept
  assign push_ok = dbr.dbr_push & (~dbr.dbr_full | pop);

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DBR_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= dbr.dbr_target_in;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        (push_ok & ~pop): count <= count + 1'b1;
        (pop & ~push_ok): count <= count - 1'b1;
        default:          count <= count;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_valid <= 1'b0;
      byp_num   <= '0;
      byp_data  <= '0;
    end else begin
      byp_valid <= wb_en_out;
      byp_num   <= wb_num_out;
      byp_data  <= wb_data_out;
    end
  end
`else
  assign byp_valid = 1'b0;
  assign byp_num   = '0;
  assign byp_data  = '0;
`endif

endmodule
